// File: rtl/dmem_responder_if.sv
// Request/response bus between the datapath (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        i_req;
    logic        i_we;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ack;
    logic [31:0] o_rdata;
    logic        o_busy;
    logic        o_err;

    modport master (
        output i_req, i_we, i_addr, i_wdata,
        input  o_ack, o_rdata, o_busy, o_err
    );

    modport slave (
        input  i_req, i_we, i_addr, i_wdata,
        output o_ack, o_rdata, o_busy, o_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed number of wait states and a one-cycle
// completion pulse; misaligned or out-of-range accesses complete with o_err.
module dmem_responder #(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    dmem_responder_if.slave   bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             fault_q, fault_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [31:0]      mem_q [DEPTH];

    logic             acc_we_c;
    logic [31:0]      acc_addr_c;
    logic [31:0]      acc_wdata_c;
    logic             fault_c;
    logic [IDX_W-1:0] idx_c;
    logic             enter_resp_c;
    logic             mem_we_c;

    // With zero wait states RESP is entered on the accepting edge, so the
    // access is resolved from the live bus instead of the latched copy.
    assign acc_we_c    = (state_q == S_IDLE) ? bus.i_we    : we_q;
    assign acc_addr_c  = (state_q == S_IDLE) ? bus.i_addr  : addr_q;
    assign acc_wdata_c = (state_q == S_IDLE) ? bus.i_wdata : wdata_q;

    assign fault_c  = (acc_addr_c[1:0] != 2'b00) || (acc_addr_c[31:2] >= 30'(DEPTH));
    assign idx_c    = acc_addr_c[IDX_W+1:2];
    assign mem_we_c = enter_resp_c && acc_we_c && !fault_c && !i_rst;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        fault_d      = fault_q;
        rdata_d      = rdata_q;
        enter_resp_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_req) begin
                    we_d    = bus.i_we;
                    addr_d  = bus.i_addr;
                    wdata_d = bus.i_wdata;
                    if (WAIT_CYC == 0) begin
                        state_d      = S_RESP;
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYC);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = S_RESP;
                    enter_resp_c = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Resolve the access on the edge entering RESP; stores keep o_rdata.
        if (enter_resp_c) begin
            fault_d = fault_c;
            if (!acc_we_c) begin
                rdata_d = fault_c ? 32'h0 : mem_q[idx_c];
            end
        end

        // Moore outputs follow the current state by one register stage.
        busy_d = (state_q != S_IDLE);
        ack_d  = (state_q == S_RESP);
        err_d  = (state_q == S_RESP) && fault_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array is deliberately outside reset.
    always_ff @(posedge i_clk) begin
        if (mem_we_c) begin
            mem_q[idx_c] <= acc_wdata_c;
        end
    end

    assign bus.o_ack   = ack_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_err   = err_q;
    assign bus.o_rdata = rdata_q;

endmodule
